// File: rtl/saturn_pkg.sv
// Shared types and constants for the Saturn nibble bus sequencer.
package saturn_pkg;

    localparam int ADDR_W = 20;

    localparam logic [7:0] NUL = 8'h00;

    typedef enum logic [1:0] {
        PH_ADDR = 2'd0,
        PH_READ = 2'd1,
        PH_ASM  = 2'd2,
        PH_DONE = 2'd3
    } phase_e;

endpackage

// File: rtl/saturn_rom.sv
// Synchronous nibble ROM for the Saturn bus sequencer; one clock read latency.
// The ROM image is supplied externally into mem.
module saturn_rom #(
    parameter int    ADDR_W    = saturn_pkg::ADDR_W,
    parameter int    ROM_DEPTH = 256,
    parameter string ROM_FILE  = "rom.hex"
) (
    input  logic              i_clk,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [3:0]        o_data
);

    localparam int AW = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1;

    logic [3:0]    mem [0:ROM_DEPTH-1];
    logic [3:0]    data_q;
    logic [3:0]    data_d;
    logic [AW-1:0] idx;
    logic          unused_addr_hi;

    assign idx            = i_addr[AW-1:0];
    assign unused_addr_hi = |(i_addr >> AW);

    always_comb begin
        data_d = mem[idx];
    end

    always_ff @(posedge i_clk) begin
        data_q <= data_d;
    end

    assign o_data = data_q;

endmodule

// File: rtl/saturn_bus.sv
// Saturn 4-phase nibble bus sequencer: fetches ROM nibbles, emits bytes, halts on NUL/end.
// Optional simulation trace with `define SATURN_BUS_TRACE_EN.
module saturn_bus #(
    parameter int    ADDR_W    = saturn_pkg::ADDR_W,
    parameter int    ROM_DEPTH = 256,
    parameter string ROM_FILE  = "rom.hex"
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_clk_en,
    output logic        o_halt,
    output logic [1:0]  o_phase,
    output logic [31:0] o_cycle_ctr,
    output logic [7:0]  o_char_to_send
);

    import saturn_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(ROM_DEPTH - 1);

    phase_e            phase_q, phase_d;
    logic              halt_q, halt_d;
    logic [31:0]       ctr_q, ctr_d;
    logic [7:0]        char_q, char_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [3:0]        latch_q, latch_d;
    logic [3:0]        low_q, low_d;
    logic [3:0]        rom_data;
    logic [7:0]        byte_w;
    logic              last_w;

    saturn_rom #(
        .ADDR_W    (ADDR_W),
        .ROM_DEPTH (ROM_DEPTH),
        .ROM_FILE  (ROM_FILE)
    ) u_rom (
        .i_clk  (i_clk),
        .i_addr (pc_q),
        .o_data (rom_data)
    );

    assign byte_w = {latch_q, low_q};
    assign last_w = (pc_q == LAST_PC);

    always_comb begin
        phase_d = phase_q;
        halt_d  = halt_q;
        ctr_d   = ctr_q;
        char_d  = char_q;
        pc_d    = pc_q;
        latch_d = latch_q;
        low_d   = low_q;
        if (i_clk_en && !halt_q) begin
            unique case (phase_q)
                PH_ADDR: begin
                    phase_d = PH_READ;
                end
                PH_READ: begin
                    latch_d = rom_data;
                    phase_d = PH_ASM;
                end
                PH_ASM: begin
                    if (!pc_q[0]) low_d = latch_q;
                    phase_d = PH_DONE;
                end
                PH_DONE: begin
                    ctr_d   = ctr_q + 32'd1;
                    phase_d = PH_ADDR;
                    if (pc_q[0]) begin
                        if (byte_w == NUL) halt_d = 1'b1;
                        else               char_d = byte_w;
                    end
                    // end of ROM wins, dropping any dangling low nibble
                    if (last_w) halt_d = 1'b1;
                    if (halt_d) phase_d = PH_DONE;
                    else        pc_d    = pc_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            phase_q <= PH_ADDR;
            halt_q  <= 1'b0;
            ctr_q   <= '0;
            char_q  <= '0;
            pc_q    <= '0;
            latch_q <= '0;
            low_q   <= '0;
        end else begin
            phase_q <= phase_d;
            halt_q  <= halt_d;
            ctr_q   <= ctr_d;
            char_q  <= char_d;
            pc_q    <= pc_d;
            latch_q <= latch_d;
            low_q   <= low_d;
        end
    end

    assign o_halt         = halt_q;
    assign o_phase        = phase_q;
    assign o_cycle_ctr    = ctr_q;
    assign o_char_to_send = char_q;

`ifdef SATURN_BUS_TRACE_EN
`ifndef SYNTHESIS
    always @(posedge i_clk) begin
        if (!i_reset && i_clk_en && !halt_q && phase_q == PH_DONE)
            $display("saturn_bus: cycle %0d pc %05h nibble %h",
                     ctr_q + 32'd1, pc_q, latch_q);
        if (!i_reset && halt_d && !halt_q)
            $display("saturn_bus: HALT");
    end
`endif
`endif

endmodule

// File: tb/tb_saturn_bus.sv
// Self-checking bench for saturn_bus against a byte-stream reference model.
module tb_saturn_bus;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, en = 1'b0;
    logic        halt;
    logic [1:0]  phase;
    logic [31:0] ctr;
    logic [7:0]  chr;

    logic        rst4 = 1'b1, en4 = 1'b0;
    logic        halt4;
    logic [1:0]  phase4;
    logic [31:0] ctr4;
    logic [7:0]  chr4;

    saturn_bus #(.ROM_DEPTH(256), .ROM_FILE("")) dut (
        .i_clk(clk), .i_reset(rst), .i_clk_en(en),
        .o_halt(halt), .o_phase(phase),
        .o_cycle_ctr(ctr), .o_char_to_send(chr)
    );

    saturn_bus #(.ROM_DEPTH(4), .ROM_FILE("")) dut4 (
        .i_clk(clk), .i_reset(rst4), .i_clk_en(en4),
        .o_halt(halt4), .o_phase(phase4),
        .o_cycle_ctr(ctr4), .o_char_to_send(chr4)
    );

    int checks = 0;
    int errors = 0;
    logic [3:0] ref_rom [256];
    int ref_depth = 256;

    // Expected {halt, phase, ctr, char} after n enabled edges since reset.
    // Cycle k completes on edge 4(k+1); odd k emits byte {rom[k], rom[k-1]}.
    task automatic ref_state(input int n, output logic [42:0] e);
        logic        h;
        logic [1:0]  ph;
        logic [31:0] c;
        logic [7:0]  ch;
        logic [7:0]  b;
        h  = 1'b0;
        ch = 8'h00;
        c  = 32'(n / 4);
        ph = 2'(n % 4);
        for (int k = 0; k < n / 4; k++) begin
            if (k % 2 == 1) begin
                b = {ref_rom[k], ref_rom[k-1]};
                if (b == 8'h00) h = 1'b1;
                else            ch = b;
            end
            if (k == ref_depth - 1) h = 1'b1;
            if (h) begin
                c  = 32'(k + 1);
                ph = 2'd3;
                break;
            end
        end
        e = {h, ph, c, ch};
    endtask

    task automatic sync_rom();
        for (int i = 0; i < 256; i++) dut.u_rom.mem[i] = ref_rom[i];
        for (int i = 0; i < 4; i++) dut4.u_rom.mem[i] = ref_rom[i];
    endtask

    task automatic load_hi();
        ref_rom = '{default: 4'h0};
        ref_rom[0] = 4'h8; ref_rom[1] = 4'h4;
        ref_rom[2] = 4'h9; ref_rom[3] = 4'h6;
        ref_depth = 256;
        sync_rom();
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1; rst4 = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0; rst4 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; en4 = 1'b0;
        do_reset(3);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({halt, phase, ctr, chr} !== 43'd0) begin
                errors++;
                $display("FAIL reset_idle clk=%0d got %h want 0", i,
                         {halt, phase, ctr, chr});
            end
        end
    endtask

    task automatic test_basic();
        logic [42:0] e;
        load_hi();
        en = 1'b0;
        do_reset(1);
        for (int n = 1; n <= 28; n++) begin
            en = 1'b1;
            @(posedge clk); #1;
            ref_state(n, e);
            checks++;
            if ({halt, phase, ctr, chr} !== e) begin
                errors++;
                $display("FAIL basic n=%0d got %h want %h", n,
                         {halt, phase, ctr, chr}, e);
            end
            if (n == 8 || n == 16 || n == 24) begin
                checks++;
                if ((n == 8 && (chr !== 8'h48 || ctr !== 32'd2)) ||
                    (n == 16 && (chr !== 8'h69 || ctr !== 32'd4)) ||
                    (n == 24 && (chr !== 8'h69 || ctr !== 32'd6 ||
                                 halt !== 1'b1 || phase !== 2'd3))) begin
                    errors++;
                    $display("FAIL basic_mark n=%0d got chr=%02h ctr=%0d halt=%b ph=%0d",
                             n, chr, ctr, halt, phase);
                end
            end
        end
        en = 1'b0;
    endtask

    task automatic test_enable_gating();
        logic [42:0] e;
        int          n;
        load_hi();
        en = 1'b0;
        do_reset(1);
        n = 0;
        for (int i = 0; i < 150; i++) begin
            en = (i % 5 == 0);
            @(posedge clk); #1;
            if (en) n++;
            ref_state(n, e);
            checks++;
            if ({halt, phase, ctr, chr} !== e) begin
                errors++;
                $display("FAIL gating clk=%0d n=%0d got %h want %h", i, n,
                         {halt, phase, ctr, chr}, e);
            end
            if (en && n == 8) begin
                checks++;
                if (chr !== 8'h48) begin
                    errors++;
                    $display("FAIL gating_48 got %02h want 48", chr);
                end
            end
        end
        en = 1'b0;
    endtask

    task automatic test_halt_sticky();
        logic [42:0] e;
        ref_state(1000, e);
        for (int i = 0; i < 50; i++) begin
            en = 1'b1;
            @(posedge clk); #1;
            checks++;
            if ({halt, phase, ctr, chr} !== e) begin
                errors++;
                $display("FAIL sticky clk=%0d got %h want %h", i,
                         {halt, phase, ctr, chr}, e);
            end
        end
        do_reset(1);
        checks++;
        if ({halt, phase, ctr, chr} !== 43'd0) begin
            errors++;
            $display("FAIL sticky_reset got %h want 0", {halt, phase, ctr, chr});
        end
        for (int n = 1; n <= 26; n++) begin
            @(posedge clk); #1;
            ref_state(n, e);
            checks++;
            if ({halt, phase, ctr, chr} !== e) begin
                errors++;
                $display("FAIL replay n=%0d got %h want %h", n,
                         {halt, phase, ctr, chr}, e);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_end_of_rom();
        logic [42:0] e;
        ref_rom = '{default: 4'h0};
        ref_rom[0] = 4'h1; ref_rom[1] = 4'h4;
        ref_rom[2] = 4'h2; ref_rom[3] = 4'h4;
        ref_depth = 4;
        sync_rom();
        en4 = 1'b0;
        do_reset(1);
        for (int n = 1; n <= 24; n++) begin
            en4 = 1'b1;
            @(posedge clk); #1;
            ref_state(n, e);
            checks++;
            if ({halt4, phase4, ctr4, chr4} !== e) begin
                errors++;
                $display("FAIL eor n=%0d got %h want %h", n,
                         {halt4, phase4, ctr4, chr4}, e);
            end
            if (n == 15 || n == 16) begin
                checks++;
                if ((n == 15 && (chr4 !== 8'h41 || halt4 !== 1'b0)) ||
                    (n == 16 && (chr4 !== 8'h42 || halt4 !== 1'b1 ||
                                 ctr4 !== 32'd4))) begin
                    errors++;
                    $display("FAIL eor_mark n=%0d got chr=%02h halt=%b ctr=%0d",
                             n, chr4, halt4, ctr4);
                end
            end
        end
        en4 = 1'b0;
        ref_depth = 256;
    endtask

    task automatic test_mid_reset();
        logic [42:0] e;
        load_hi();
        en = 1'b0;
        do_reset(1);
        en = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (phase !== 2'd2 || ctr !== 32'd2) begin
            errors++;
            $display("FAIL mid_pre got ph=%0d ctr=%0d want 2 2", phase, ctr);
        end
        do_reset(1);
        checks++;
        if ({halt, phase, ctr, chr} !== 43'd0) begin
            errors++;
            $display("FAIL mid_reset got %h want 0", {halt, phase, ctr, chr});
        end
        for (int n = 1; n <= 8; n++) begin
            @(posedge clk); #1;
            ref_state(n, e);
            checks++;
            if ({halt, phase, ctr, chr} !== e) begin
                errors++;
                $display("FAIL mid_replay n=%0d got %h want %h", n,
                         {halt, phase, ctr, chr}, e);
            end
        end
        checks++;
        if (chr !== 8'h48) begin
            errors++;
            $display("FAIL mid_48 got %02h want 48", chr);
        end
        en = 1'b0;
    endtask

    task automatic test_random();
        logic [42:0] e;
        int          n;
        for (int it = 0; it < 3; it++) begin
            ref_depth = 256;
            for (int i = 0; i < 256; i++) ref_rom[i] = 4'($urandom_range(0, 15));
            for (int i = 1; i < 256; i += 2)
                if (it > 0 && $urandom_range(0, 39) == 0) begin
                    ref_rom[i] = 4'h0; ref_rom[i-1] = 4'h0;
                end
            sync_rom();
            en = 1'b0;
            do_reset(1);
            n = 0;
            for (int i = 0; i < 1500; i++) begin
                en = ($urandom_range(0, 3) != 0);
                @(posedge clk); #1;
                if (en) n++;
                ref_state(n, e);
                checks++;
                if ({halt, phase, ctr, chr} !== e) begin
                    errors++;
                    $display("FAIL random it=%0d clk=%0d got %h want %h", it, i,
                             {halt, phase, ctr, chr}, e);
                end
            end
        end
        en = 1'b0;
        for (int it = 0; it < 6; it++) begin
            ref_depth = 4;
            for (int i = 0; i < 4; i++) ref_rom[i] = 4'($urandom_range(0, 15));
            if (it % 3 == 0) begin ref_rom[0] = 4'h0; ref_rom[1] = 4'h0; end
            sync_rom();
            en4 = 1'b0;
            do_reset(1);
            n = 0;
            for (int i = 0; i < 30; i++) begin
                en4 = ($urandom_range(0, 2) != 0);
                @(posedge clk); #1;
                if (en4) n++;
                ref_state(n, e);
                checks++;
                if ({halt4, phase4, ctr4, chr4} !== e) begin
                    errors++;
                    $display("FAIL random4 it=%0d clk=%0d got %h want %h", it, i,
                             {halt4, phase4, ctr4, chr4}, e);
                end
            end
        end
        en4 = 1'b0;
        ref_depth = 256;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_enable_gating();
        test_halt_sticky();
        test_end_of_rom();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/saturn_bus.md
Name: saturn_bus

Overview:
- Nibble-wide bus sequencer for the Saturn core.
- Runs a 4-phase bus cycle; each cycle fetches one nibble from an internal program ROM at a 20-bit nibble address.
- Assembles nibble pairs into bytes and presents them on a character output port.
- Counts completed bus cycles and raises a sticky halt on a NUL byte or at the end of the ROM. Sits directly under the board/sim top, which gates it with a slow clock enable.

Parameters:
- ADDR_W, 20, nibble address width (Saturn address space).
- ROM_DEPTH, 256, number of nibbles in the internal ROM (power of two, ≤ 2^ADDR_W).
- ROM_FILE, "rom.hex", $readmemh image, one hex nibble per line.

Ports:
- i_clk  input  1  system clock.
- i_reset  input  1  reset; synchronous, active-high.
- i_clk_en  input  1  advance enable; state moves only on i_clk edges with i_clk_en=1.
- o_halt  output  1  sticky halt flag.
- o_phase  output  2  current bus phase 0..3.
- o_cycle_ctr  output  32  completed bus cycles.
- o_char_to_send  output  8  last non-NUL byte assembled.

Behaviour:
- Reset:
  - Has priority over i_clk_en.
  - Sets o_halt=0, o_phase=0, o_cycle_ctr=0, o_char_to_send=0, pc=0, nibble latch=0, low-nibble holding register=0.
  - Asserting reset mid-cycle or while halted fully restarts from address 0.
- Phase sequencing (only when i_clk_en=1 and !o_halt): phase 0→1→2→3→0, one step per enabled clock.
  - Phase 0: present pc as the ROM address.
  - Phase 1: latch rom[pc] into the nibble latch (synchronous ROM read, one clock of latency).
  - Phase 2: if pc[0]=0, copy the latch into the low-nibble register. If pc[0]=1, form byte = {latch, low}.
  - Phase 3: cycle completes.
- End of a completed cycle (phase 3):
  - o_cycle_ctr increments by 1 (wraps modulo 2^32).
  - If pc[0]=1 and byte≠0x00: o_char_to_send<=byte.
  - If pc[0]=1 and byte=0x00: o_halt<=1; o_char_to_send is unchanged.
  - If pc=ROM_DEPTH-1: o_halt<=1, even if a valid byte was just emitted on the same edge. The final byte is still written.
  - Otherwise pc<=pc+1.
- Halt:
  - Once o_halt=1, phase, counter, pc and char are all frozen; o_phase stays at 3.
  - i_clk_en is ignored until reset.
- i_clk_en=0: all state holds; outputs stable.
- Odd-length ROM ending: the halt at the ROM end takes priority. A dangling low nibble is discarded.
- All outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- SATURN_BUS_TRACE_EN.
- Defined: a simulation-only $display at every completed cycle prints cycle count, pc (5 hex digits) and nibble. A "HALT" line prints when o_halt rises. The block is excluded from synthesis via `ifndef SYNTHESIS.
- Undefined: no trace code; functionally identical.

Decomposition:
- Package saturn_pkg holds:
  - the phase enum (PH_ADDR=0, PH_READ=1, PH_ASM=2, PH_DONE=3);
  - ADDR_W;
  - the NUL constant 8'h00.
- One natural sub-module: saturn_rom (synchronous nibble ROM, parameterised by ADDR_W, ROM_DEPTH and ROM_FILE). The sequencer stays in saturn_bus.

Test Plan:
- Reset and idle: hold i_reset 3 clocks, then i_clk_en=0 for 10 clocks → o_phase=0, o_cycle_ctr=0, o_halt=0, o_char_to_send=0x00 throughout.
- Basic string: ROM nibbles 8,4,9,6,0,0 with i_clk_en=1 continuously.
  - After 8 enabled clocks: o_char_to_send=0x48, o_cycle_ctr=2.
  - After 16 enabled clocks: o_char_to_send=0x69, o_cycle_ctr=4.
  - After 24 enabled clocks: o_halt=1, o_cycle_ctr=6, o_char_to_send still 0x69, o_phase=3.
- Enable gating: same ROM, i_clk_en pulsed 1 clock in every 5 → identical sequence of values, each transition only on enabled edges; 0x48 appears after the 8th pulse.
- Halt stickiness: after halt, keep i_clk_en=1 for 50 clocks → all outputs unchanged. Then assert i_reset 1 clock → outputs return to 0; the string replays.
- End of ROM: ROM_DEPTH=4, nibbles 1,4,2,4 → 0x41 then 0x42 emitted. o_halt=1 on the same edge that 0x42 appears, with o_cycle_ctr=4.
- Mid-cycle reset: assert i_reset while o_phase=2 in the 3rd cycle → next clock all outputs 0, pc=0; the first byte 0x48 reappears after 8 further enabled clocks.
